bnn_layer_sequencer: RTL and testbench

- Controller that runs one fully-connected binarized layer.
- It walks the W and X memories, accumulates the XNOR-popcount of 1-bit weights and activations per output neuron, and writes each sign result back to X memory.
- It sits between the top-level control FSM, which starts a layer and waits for done, and the W/X memory ports.
- It replaces the open-loop stimulus of the compute bench.

---
 rtl/bnn_layer_sequencer_if.sv | 29 ++
 rtl/bnn_layer_sequencer.sv | 147 ++++++++++++++
 tb/tb_bnn_layer_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_layer_sequencer_if.sv
// W/X memory port bundle between the layer sequencer (master) and the
// weight/activation memories (slave).
interface bnn_layer_sequencer_if #(
    parameter int unsigned W_ADDR_LEN = 20,
    parameter int unsigned X_ADDR_LEN = 10,
    parameter int unsigned W_SEL_LEN  = 2,
    parameter int unsigned X_SEL_LEN  = 2
);
    logic [W_ADDR_LEN-1:0] w_addr;
    logic                  w_data;
    logic [W_SEL_LEN-1:0]  w_sel;
    logic                  w_rq;
    logic [X_ADDR_LEN-1:0] x_addr;
    logic                  x_data;
    logic [X_SEL_LEN-1:0]  x_sel;
    logic                  x_rq;
    logic                  x_wq;
    logic                  x_wdata;

    modport master (
        output w_addr, w_sel, w_rq, x_addr, x_sel, x_rq, x_wq, x_wdata,
        input  w_data, x_data
    );

    modport slave (
        input  w_addr, w_sel, w_rq, x_addr, x_sel, x_rq, x_wq, x_wdata,
        output w_data, x_data
    );
endinterface

// File: rtl/bnn_layer_sequencer.sv
// Runs one fully-connected binarized layer: streams W/X bits, counts XNOR
// matches per neuron and writes each neuron's sign bit back to X memory.
module bnn_layer_sequencer #(
    parameter int unsigned W_ADDR_LEN = 20,
    parameter int unsigned X_ADDR_LEN = 10,
    parameter int unsigned W_SEL_LEN  = 2,
    parameter int unsigned X_SEL_LEN  = 2,
    parameter int unsigned ALU_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [X_ADDR_LEN-1:0] n_in,
    input  logic [X_ADDR_LEN-1:0] n_out,
    input  logic [W_ADDR_LEN-1:0] w_base,
    input  logic [W_SEL_LEN-1:0]  w_bank,
    input  logic [X_SEL_LEN-1:0]  x_src,
    input  logic [X_SEL_LEN-1:0]  x_dst,
    output logic                  busy,
    output logic                  done,
    bnn_layer_sequencer_if.master mem
);
    localparam logic [X_ADDR_LEN-1:0] X_ONE = X_ADDR_LEN'(1);
    localparam logic [W_ADDR_LEN-1:0] W_ONE = W_ADDR_LEN'(1);
    localparam logic [ALU_WIDTH-1:0]  A_ONE = ALU_WIDTH'(1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [X_ADDR_LEN-1:0] n_in_q, n_out_q, i_q, j_q, x_addr_q;
    logic [W_ADDR_LEN-1:0] w_ptr_q, w_addr_q;
    logic [W_SEL_LEN-1:0]  w_bank_q, w_sel_q;
    logic [X_SEL_LEN-1:0]  x_src_q, x_dst_q, x_sel_q;
    logic [ALU_WIDTH-1:0]  acc_q, acc_d;
    logic                  vld_q;
    logic                  last_i, last_j, result;

    assign last_i = (i_q == n_in_q - X_ONE);
    assign last_j = (j_q == n_out_q - X_ONE);
    // 2*matches >= n_in, evaluated one bit wider than the accumulator
    assign result = ({acc_q, 1'b0} >= (ALU_WIDTH + 1)'(n_in_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (n_in != '0 && n_out != '0) ? S_FETCH : S_DONE;
            S_FETCH: if (last_i) state_d = S_DRAIN;
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: state_d = last_j ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read data lands one cycle after its request; vld_q marks that cycle
    always_comb begin
        acc_d = acc_q;
        if (state_q == S_FETCH && i_q == '0) acc_d = '0;
        if (vld_q && (mem.w_data == mem.x_data)) acc_d = acc_d + A_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_in_q   <= '0;
            n_out_q  <= '0;
            w_bank_q <= '0;
            x_src_q  <= '0;
            x_dst_q  <= '0;
            i_q      <= '0;
            j_q      <= '0;
            w_ptr_q  <= '0;
            acc_q    <= '0;
            vld_q    <= 1'b0;
            w_addr_q <= '0;
            w_sel_q  <= '0;
            x_addr_q <= '0;
            x_sel_q  <= '0;
        end else begin
            vld_q <= (state_q == S_FETCH);
            acc_q <= acc_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_in_q   <= n_in;
                        n_out_q  <= n_out;
                        w_bank_q <= w_bank;
                        x_src_q  <= x_src;
                        x_dst_q  <= x_dst;
                        i_q      <= '0;
                        j_q      <= '0;
                        w_ptr_q  <= w_base;
                    end
                end
                S_FETCH: begin
                    w_ptr_q  <= w_ptr_q + W_ONE;
                    i_q      <= last_i ? '0 : i_q + X_ONE;
                    w_addr_q <= w_ptr_q;
                    w_sel_q  <= w_bank_q;
                    x_addr_q <= i_q;
                    x_sel_q  <= x_src_q;
                end
                S_WRITE: begin
                    x_addr_q <= j_q;
                    x_sel_q  <= x_dst_q;
                    if (!last_j) j_q <= j_q + X_ONE;
                end
                default: ;
            endcase
        end
    end

    // Address/select outputs show the live value while strobing, else the last one driven
    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        mem.w_rq    = 1'b0;
        mem.x_rq    = 1'b0;
        mem.x_wq    = 1'b0;
        mem.x_wdata = 1'b0;
        mem.w_addr  = w_addr_q;
        mem.w_sel   = w_sel_q;
        mem.x_addr  = x_addr_q;
        mem.x_sel   = x_sel_q;
        case (state_q)
            S_FETCH: begin
                mem.w_rq   = 1'b1;
                mem.w_addr = w_ptr_q;
                mem.w_sel  = w_bank_q;
                mem.x_rq   = 1'b1;
                mem.x_addr = i_q;
                mem.x_sel  = x_src_q;
            end
            S_WRITE: begin
                mem.x_wq    = 1'b1;
                mem.x_addr  = j_q;
                mem.x_sel   = x_dst_q;
                mem.x_wdata = result;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Directed bench for bnn_layer_sequencer with a 1-cycle-latency W/X memory
// model and hand-computed expectations.
module tb_bnn_layer_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  n_in, n_out;
    logic [19:0] w_base;
    logic [1:0]  w_bank, x_src, x_dst;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

    bnn_layer_sequencer_if #(.W_ADDR_LEN(20), .X_ADDR_LEN(10), .W_SEL_LEN(2), .X_SEL_LEN(2)) mem ();

    bnn_layer_sequencer #(
        .W_ADDR_LEN(20), .X_ADDR_LEN(10), .W_SEL_LEN(2), .X_SEL_LEN(2), .ALU_WIDTH(12)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n_in(n_in), .n_out(n_out),
        .w_base(w_base), .w_bank(w_bank), .x_src(x_src), .x_dst(x_dst),
        .busy(busy), .done(done), .mem(mem.master)
    );

    always #5 clk = ~clk;

    bit wmem [logic [19:0]];
    bit xmem [4][1024];

    int          done_cyc, n_rq, n_wq, n_overlap, n_busy_low, n_wsel_bad;
    logic [19:0] wa[$];
    int          wr_addr[$];
    int          wr_sel[$];
    bit          wr_data[$];

    task automatic load_w(input logic [19:0] base, input logic [3:0] bits);
        for (int i = 0; i < 4; i++) wmem[base + 20'(i)] = bits[3-i];
    endtask

    task automatic load_x(input int bank, input logic [3:0] bits);
        for (int i = 0; i < 4; i++) xmem[bank][i] = bits[3-i];
    endtask

    // Starts a layer, serves memory reads/writes, records activity until done or stop_cyc.
    task automatic run_layer(input int ni, input int no, input logic [19:0] base, input int wb,
                             input int xs, input int xd, input int pulse_cyc, input int stop_cyc);
        bit pend_w, pend_x;
        pend_w = 0; pend_x = 0;
        done_cyc = -1; n_rq = 0; n_wq = 0; n_overlap = 0; n_busy_low = 0; n_wsel_bad = 0;
        wa.delete(); wr_addr.delete(); wr_sel.delete(); wr_data.delete();
        @(negedge clk);
        n_in = 10'(ni); n_out = 10'(no); w_base = base;
        w_bank = 2'(wb); x_src = 2'(xs); x_dst = 2'(xd); start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= stop_cyc; k++) begin
            @(negedge clk);
            start  = (k == pulse_cyc);
            n_in   = (k == pulse_cyc) ? 10'd2 : 10'(ni);
            w_base = (k == pulse_cyc) ? 20'h00000 : base;
            mem.w_data = pend_w;
            mem.x_data = pend_x;
            if (mem.w_rq) begin
                pend_w = wmem.exists(mem.w_addr) ? wmem[mem.w_addr] : 1'b0;
                wa.push_back(mem.w_addr);
                if (mem.w_sel != 2'(wb)) n_wsel_bad++;
            end
            if (mem.x_rq) pend_x = xmem[mem.x_sel][mem.x_addr];
            if (mem.w_rq || mem.x_rq) n_rq++;
            if (mem.x_wq) begin
                n_wq++;
                xmem[mem.x_sel][mem.x_addr] = mem.x_wdata;
                wr_addr.push_back(int'(mem.x_addr));
                wr_sel.push_back(int'(mem.x_sel));
                wr_data.push_back(mem.x_wdata);
            end
            if (mem.x_rq && mem.x_wq) n_overlap++;
            if (!busy) n_busy_low++;
            if (done) begin
                done_cyc = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; n_in = '0; n_out = '0; w_base = '0;
        w_bank = '0; x_src = '0; x_dst = '0;
        mem.w_data = 1'b0; mem.x_data = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if ({mem.w_rq, mem.x_rq, mem.x_wq, mem.x_wdata} !== 4'b0)
            begin errors++; $display("FAIL reset_strobes got=%b exp=0000", {mem.w_rq, mem.x_rq, mem.x_wq, mem.x_wdata}); end
        checks++; if ({mem.w_addr, mem.x_addr, mem.w_sel, mem.x_sel} !== 34'b0)
            begin errors++; $display("FAIL reset_addr got=%h exp=0", {mem.w_addr, mem.x_addr, mem.w_sel, mem.x_sel}); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        wmem.delete();
        load_w(20'h00010, 4'b1011);
        load_w(20'h00014, 4'b0000);
        load_x(0, 4'b1001);
        xmem[1][0] = 0; xmem[1][1] = 0;
        run_layer(4, 2, 20'h00010, 2, 0, 1, -1, 200);
        checks++; if (done_cyc != 13) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=13", done_cyc); end
        checks++; if (wa.size() != 8) begin errors++; $display("FAIL basic_wreq_count got=%0d exp=8", wa.size()); end
        for (int i = 0; i < 8 && i < wa.size(); i++) begin
            checks++; if (wa[i] !== 20'h00010 + 20'(i))
                begin errors++; $display("FAIL basic_waddr[%0d] got=%h exp=%h", i, wa[i], 20'h00010 + 20'(i)); end
        end
        checks++; if (n_wq != 2) begin errors++; $display("FAIL basic_write_count got=%0d exp=2", n_wq); end
        checks++; if (xmem[1][0] !== 1'b1 || xmem[1][1] !== 1'b1)
            begin errors++; $display("FAIL basic_xdst got=%b%b exp=11", xmem[1][0], xmem[1][1]); end
        if (wr_addr.size() == 2) begin
            checks++; if (wr_addr[0] != 0 || wr_addr[1] != 1 || wr_sel[0] != 1 || wr_sel[1] != 1)
                begin errors++; $display("FAIL basic_write_addr got=%0d,%0d sel=%0d,%0d exp=0,1 sel=1,1", wr_addr[0], wr_addr[1], wr_sel[0], wr_sel[1]); end
        end
        checks++; if (n_overlap != 0) begin errors++; $display("FAIL basic_rq_wq_overlap got=%0d exp=0", n_overlap); end
        checks++; if (n_wsel_bad != 0) begin errors++; $display("FAIL basic_wsel got=%0d bad exp=0", n_wsel_bad); end
        checks++; if (n_busy_low != 0) begin errors++; $display("FAIL basic_busy got=%0d low cycles exp=0", n_busy_low); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL basic_idle_after got busy=%b done=%b exp=0,0", busy, done); end
        checks++; if (mem.x_addr !== 10'd1 || mem.x_sel !== 2'd1 || mem.w_addr !== 20'h00017)
            begin errors++; $display("FAIL basic_hold got x_addr=%0d x_sel=%0d w_addr=%h exp=1,1,00017", mem.x_addr, mem.x_sel, mem.w_addr); end
    endtask

    task automatic test_tie();
        wmem.delete();
        load_w(20'h00100, 4'b1110);
        load_w(20'h00104, 4'b1100);
        load_x(2, 4'b1001);
        xmem[3][0] = 1; xmem[3][1] = 0;
        run_layer(4, 2, 20'h00100, 1, 2, 3, -1, 200);
        checks++; if (done_cyc != 13) begin errors++; $display("FAIL tie_done_cycle got=%0d exp=13", done_cyc); end
        checks++; if (xmem[3][0] !== 1'b0) begin errors++; $display("FAIL tie_neg_result got=%b exp=0", xmem[3][0]); end
        checks++; if (xmem[3][1] !== 1'b1) begin errors++; $display("FAIL tie_equal_result got=%b exp=1", xmem[3][1]); end
    endtask

    task automatic test_zero();
        run_layer(0, 3, 20'h00010, 0, 0, 1, -1, 50);
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_nin_done got=%0d exp=1", done_cyc); end
        checks++; if (n_rq != 0 || n_wq != 0) begin errors++; $display("FAIL zero_nin_access got rq=%0d wq=%0d exp=0,0", n_rq, n_wq); end
        @(negedge clk);
        run_layer(3, 0, 20'h00010, 0, 0, 1, -1, 50);
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_nout_done got=%0d exp=1", done_cyc); end
        checks++; if (n_rq != 0 || n_wq != 0) begin errors++; $display("FAIL zero_nout_access got rq=%0d wq=%0d exp=0,0", n_rq, n_wq); end
    endtask

    task automatic test_wrap();
        logic [19:0] exp_a [4];
        exp_a[0] = 20'hFFFFE; exp_a[1] = 20'hFFFFF; exp_a[2] = 20'h00000; exp_a[3] = 20'h00001;
        wmem.delete();
        for (int i = 0; i < 4; i++) wmem[exp_a[i]] = 1'b1;
        load_x(0, 4'b1001);
        xmem[2][0] = 0;
        run_layer(4, 1, 20'hFFFFE, 3, 0, 2, -1, 200);
        checks++; if (done_cyc != 7) begin errors++; $display("FAIL wrap_done_cycle got=%0d exp=7", done_cyc); end
        checks++; if (wa.size() != 4) begin errors++; $display("FAIL wrap_wreq_count got=%0d exp=4", wa.size()); end
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            checks++; if (wa[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_waddr[%0d] got=%h exp=%h", i, wa[i], exp_a[i]); end
        end
        checks++; if (xmem[2][0] !== 1'b1) begin errors++; $display("FAIL wrap_result got=%b exp=1", xmem[2][0]); end
    endtask

    task automatic test_start_while_busy();
        wmem.delete();
        load_w(20'h00010, 4'b1011);
        load_w(20'h00014, 4'b0000);
        load_x(0, 4'b1001);
        xmem[1][0] = 0; xmem[1][1] = 0;
        run_layer(4, 2, 20'h00010, 2, 0, 1, 3, 200);
        checks++; if (done_cyc != 13) begin errors++; $display("FAIL busy_start_done got=%0d exp=13", done_cyc); end
        checks++; if (wa.size() != 8 || n_wq != 2) begin errors++; $display("FAIL busy_start_access got reads=%0d writes=%0d exp=8,2", wa.size(), n_wq); end
        if (wa.size() == 8) begin
            checks++; if (wa[7] !== 20'h00017) begin errors++; $display("FAIL busy_start_last_waddr got=%h exp=00017", wa[7]); end
        end
        checks++; if (xmem[1][0] !== 1'b1 || xmem[1][1] !== 1'b1)
            begin errors++; $display("FAIL busy_start_xdst got=%b%b exp=11", xmem[1][0], xmem[1][1]); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_abort();
        int spur;
        wmem.delete();
        load_w(20'h00010, 4'b1011);
        load_w(20'h00014, 4'b0000);
        load_x(0, 4'b1001);
        xmem[1][0] = 0; xmem[1][1] = 0;
        run_layer(4, 2, 20'h00010, 2, 0, 1, -1, 8);
        checks++; if (mem.w_rq !== 1'b1 || mem.w_addr !== 20'h00015)
            begin errors++; $display("FAIL abort_prestate got w_rq=%b w_addr=%h exp=1,00015", mem.w_rq, mem.w_addr); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({busy, done, mem.w_rq, mem.x_rq, mem.x_wq, mem.x_wdata} !== 6'b0)
            begin errors++; $display("FAIL abort_strobes got=%b exp=000000", {busy, done, mem.w_rq, mem.x_rq, mem.x_wq, mem.x_wdata}); end
        checks++; if ({mem.w_addr, mem.x_addr, mem.w_sel, mem.x_sel} !== 34'b0)
            begin errors++; $display("FAIL abort_addr got=%h exp=0", {mem.w_addr, mem.x_addr, mem.w_sel, mem.x_sel}); end
        spur = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) spur++;
        end
        checks++; if (spur != 0) begin errors++; $display("FAIL abort_no_done got=%0d pulses exp=0", spur); end
        checks++; if (xmem[1][0] !== 1'b1 || xmem[1][1] !== 1'b0)
            begin errors++; $display("FAIL abort_partial_writes got=%b%b exp=10", xmem[1][0], xmem[1][1]); end
        rst = 1'b1;
        xmem[1][0] = 0;
        run_layer(4, 2, 20'h00010, 2, 0, 1, -1, 200);
        checks++; if (done_cyc != 13) begin errors++; $display("FAIL restart_done got=%0d exp=13", done_cyc); end
        if (wa.size() > 0) begin
            checks++; if (wa[0] !== 20'h00010) begin errors++; $display("FAIL restart_first_waddr got=%h exp=00010", wa[0]); end
        end
        if (wr_addr.size() == 2) begin
            checks++; if (wr_addr[0] != 0 || wr_addr[1] != 1) begin errors++; $display("FAIL restart_write_addr got=%0d,%0d exp=0,1", wr_addr[0], wr_addr[1]); end
        end
        checks++; if (xmem[1][0] !== 1'b1 || xmem[1][1] !== 1'b1)
            begin errors++; $display("FAIL restart_xdst got=%b%b exp=11", xmem[1][0], xmem[1][1]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_zero();
        test_wrap();
        test_start_while_busy();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
